// File: rtl/simd_dmem.sv
// Single-port 1024 x 16 data memory with registered read data for the SIMD core.
// Optional post-reset zeroing sweep is built when SIMD_DMEM_CLEAR_EN is defined.
module simd_dmem #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       data_address,
    input  logic             data_r,
    input  logic             data_w,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             rdata_valid,
    output logic             init_done,
    output logic             req_drop
);

    localparam int AW = 10;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rdata_valid_q, rdata_valid_d;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

`ifdef SIMD_DMEM_CLEAR_EN
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          req_drop_q, req_drop_d;

    assign init_done = (state_q == READY);
    assign req_drop  = req_drop_q;
`else
    assign init_done = 1'b1;
    assign req_drop  = 1'b0;
`endif

    always_comb begin
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = data_address;
        mem_wdata     = wdata;

        // data_w only qualifies a strobed access; on its own it is ignored
        if (init_done && data_r) begin
            if (data_w) begin
                mem_we = 1'b1;
            end else begin
                rdata_d       = mem[data_address];
                rdata_valid_d = 1'b1;
            end
        end

`ifdef SIMD_DMEM_CLEAR_EN
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        req_drop_d = 1'b0;
        case (state_q)
            CLEAR: begin
                // sweep owns the write port; CPU strobes are reported and dropped
                mem_we     = 1'b1;
                mem_waddr  = clr_addr_q;
                mem_wdata  = '0;
                clr_addr_d = clr_addr_q + 1'b1;
                req_drop_d = data_r;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
`ifdef SIMD_DMEM_CLEAR_EN
            state_q       <= CLEAR;
            clr_addr_q    <= '0;
            req_drop_q    <= 1'b0;
`endif
        end else begin
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
`ifdef SIMD_DMEM_CLEAR_EN
            state_q       <= state_d;
            clr_addr_q    <= clr_addr_d;
            req_drop_q    <= req_drop_d;
`endif
        end
    end

    // array itself carries no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_simd_dmem.sv
// Directed bench for simd_dmem; the sweep section is built when SIMD_DMEM_CLEAR_EN is defined.
module tb_simd_dmem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  data_address = '0;
    logic        data_r = 1'b0;
    logic        data_w = 1'b0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        init_done;
    logic        req_drop;

    int n_vec = 0;
    int n_err = 0;

    simd_dmem dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_address (data_address),
        .data_r       (data_r),
        .data_w       (data_w),
        .wdata        (wdata),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .init_done    (init_done),
        .req_drop     (req_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: apply inputs, return at the next negedge after the edge sampled them.
    task automatic drive(input logic r, input logic w, input logic [9:0] a, input logic [15:0] d);
        data_r       = r;
        data_w       = w;
        data_address = a;
        wdata        = d;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 10'd0, 16'h0000);
    endtask

`ifdef SIMD_DMEM_CLEAR_EN
    // Counts edges from the current point until init_done rises, bounded.
    task automatic wait_init(input int start, output int n);
        n = start;
        while (!init_done && n < 2000) begin
            idle();
            n++;
        end
    endtask
`endif

    initial begin
        int cycles;
        cycles = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_valid", {15'd0, rdata_valid}, 16'd0);
        check("rst_drop", {15'd0, req_drop}, 16'd0);
`ifdef SIMD_DMEM_CLEAR_EN
        check("rst_init", {15'd0, init_done}, 16'd0);
`else
        check("rst_init", {15'd0, init_done}, 16'd1);
`endif
        rst_n = 1'b1;

`ifdef SIMD_DMEM_CLEAR_EN
        for (int i = 0; i < 10; i++) begin
            idle();
            cycles++;
        end
        drive(1'b1, 1'b1, 10'd5, 16'hBEEF);
        cycles++;
        check("drop_pulse", {15'd0, req_drop}, 16'd1);
        check("drop_no_valid", {15'd0, rdata_valid}, 16'd0);
        idle();
        cycles++;
        check("drop_single", {15'd0, req_drop}, 16'd0);
        wait_init(cycles, cycles);
        check("sweep_len", 16'(cycles), 16'd1024);
        drive(1'b1, 1'b0, 10'd0, 16'h0000);
        check("clr_rd0", rdata, 16'h0000);
        check("clr_rd0_valid", {15'd0, rdata_valid}, 16'd1);
        drive(1'b1, 1'b0, 10'd511, 16'h0000);
        check("clr_rd511", rdata, 16'h0000);
        drive(1'b1, 1'b0, 10'd1023, 16'h0000);
        check("clr_rd1023", rdata, 16'h0000);
        drive(1'b1, 1'b0, 10'd5, 16'h0000);
        check("clr_rd5_dropped", rdata, 16'h0000);
`endif

        // write then read same address on the next cycle
        drive(1'b1, 1'b1, 10'd0, 16'h0014);
        check("wr0_no_valid", {15'd0, rdata_valid}, 16'd0);
        check("wr0_no_drop", {15'd0, req_drop}, 16'd0);
        drive(1'b1, 1'b0, 10'd0, 16'h0000);
        check("rd0_data", rdata, 16'h0014);
        check("rd0_valid", {15'd0, rdata_valid}, 16'd1);
        idle();
        check("rd0_valid_once", {15'd0, rdata_valid}, 16'd0);
        check("rd0_hold_idle", rdata, 16'h0014);

        // writes leave rdata alone
        drive(1'b1, 1'b1, 10'd1023, 16'h5A5A);
        check("wr1023_hold", rdata, 16'h0014);
        drive(1'b1, 1'b1, 10'd0, 16'h1234);
        check("wr0b_hold", rdata, 16'h0014);
        check("wr0b_no_valid", {15'd0, rdata_valid}, 16'd0);
        drive(1'b1, 1'b0, 10'd1023, 16'h0000);
        check("rd1023", rdata, 16'h5A5A);
        check("rd1023_valid", {15'd0, rdata_valid}, 16'd1);
        drive(1'b1, 1'b0, 10'd0, 16'h0000);
        check("rd0b_b2b", rdata, 16'h1234);
        check("rd0b_valid_b2b", {15'd0, rdata_valid}, 16'd1);

        // data_w without data_r is not a write
        drive(1'b1, 1'b1, 10'd3, 16'h00A3);
        drive(1'b0, 1'b1, 10'd3, 16'hFFFF);
        check("ign_no_valid", {15'd0, rdata_valid}, 16'd0);
        check("ign_hold", rdata, 16'h1234);
        drive(1'b1, 1'b0, 10'd3, 16'h0000);
        check("rd3_prior", rdata, 16'h00A3);
        idle();

        // reset while ready
        rst_n = 1'b0;
        idle();
        check("rst2_rdata", rdata, 16'h0000);
        check("rst2_valid", {15'd0, rdata_valid}, 16'd0);
        rst_n = 1'b1;
`ifdef SIMD_DMEM_CLEAR_EN
        for (int i = 0; i < 600; i++) begin
            idle();
        end
        check("mid_sweep_not_done", {15'd0, init_done}, 16'd0);
        rst_n = 1'b0;
        idle();
        check("rst3_rdata", rdata, 16'h0000);
        check("rst3_init", {15'd0, init_done}, 16'd0);
        rst_n = 1'b1;
        wait_init(0, cycles);
        check("sweep2_len", 16'(cycles), 16'd1024);
        drive(1'b1, 1'b0, 10'd1023, 16'h0000);
        check("sweep2_rd1023", rdata, 16'h0000);
        drive(1'b1, 1'b0, 10'd3, 16'h0000);
        check("sweep2_rd3", rdata, 16'h0000);
`else
        check("rst2_init", {15'd0, init_done}, 16'd1);
        drive(1'b1, 1'b0, 10'd1023, 16'h0000);
        check("keep_rd1023", rdata, 16'h5A5A);
        check("keep_valid", {15'd0, rdata_valid}, 16'd1);
`endif
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/simd_dmem.md
# simd_dmem

Single-port 1024 x 16 data memory for the SIMD processor, sitting directly downstream of `CPUtop` on its data port (`data_address`, `data_r`, `data_w`, `data_out` -> `data_in`). It decodes the CPU's read/write strobe protocol and performs the access on the rising clock edge. A registered read result is returned to the CPU. An optional post-reset clear sweep zeroes the array and holds the core off via `init_done`.

## Interface
- `DEPTH`, 1024: number of 16-bit words; address width is fixed at 10 bits.
- `WIDTH`, 16: data word width.
- `clk  input  1`: system clock, all state on rising edge.
- `rst_n  input  1`: reset, asynchronous, active-low.
- `data_address  input  10`: word address, from `CPUtop.data_address`.
- `data_r  input  1`: access strobe, from `CPUtop.data_r`.
- `data_w  input  1`: write qualifier, from `CPUtop.data_w`; meaningful only with `data_r`=1.
- `wdata  input  16`: write data, from `CPUtop.data_out`.
- `rdata  output  16`: registered read data, to `CPUtop.data_in`.
- `rdata_valid  output  1`: one-cycle pulse, `rdata` updated this cycle.
- `init_done  output  1`: memory usable; `CPUtop` reset must be held until high.
- `req_drop  output  1`: one-cycle pulse, a request arrived while `init_done`=0 and was ignored.

## Operation
- Access decode per cycle with `init_done`=1:
  - `data_r`=1, `data_w`=0: read.
  - `data_r`=1, `data_w`=1: write.
  - `data_r`=0: idle; `data_w` alone is ignored.
- One access per cycle; no queuing, no back-pressure once `init_done`=1.
- Read: `rdata` <= mem[`data_address`]; `rdata_valid` pulses. `rdata` holds its last value through writes and idle cycles.
- Write: mem[`data_address`] <= `wdata`; `rdata` and `rdata_valid` unchanged.
- Read immediately after a write to the same address returns the new data, because accesses are in separate cycles.
- FSM states:
  - CLEAR: sweep counter `clr_addr` 0..1023, writing 0 each cycle. Goes to READY after writing address 1023.
  - READY: normal operation.
- Reset entry state is CLEAR with the macro defined, READY without it.
- Requests with `data_r`=1 in CLEAR are dropped and pulse `req_drop`; memory contents are not altered by them.
- Reset mid-sweep aborts the sweep. On release the sweep restarts at address 0.
- Reset in READY does not clear the array without the macro.

## Timing
- Reset values: `rdata`=16'h0000, `rdata_valid`=0, `req_drop`=0, `init_done`=0 (with macro) or 1 (without), `clr_addr`=0.
- Read latency: request sampled at edge N; `rdata` and `rdata_valid` are valid after edge N and stable through cycle N+1.
- Write latency: data is committed at edge N and readable by a request sampled at edge N+1.
- Clear sweep: 1024 cycles. `init_done` rises after the edge that writes address 1023, i.e. edge 1024 counting the first post-reset edge as 1.
- `rdata_valid` and `req_drop` are never high for more than one cycle per request.

## Configuration
- `SIMD_DMEM_CLEAR_EN` defined:
  - CLEAR state and the 10-bit sweep counter are built.
  - Every reset zeroes all 1024 words before `init_done` rises.
- `SIMD_DMEM_CLEAR_EN` undefined:
  - No sweep counter.
  - `init_done` is 1 from reset and `req_drop` is tied to 0.
  - Array contents after power-up are undefined (X in simulation); software must store before loading.

## Test plan
- With macro: release `rst_n`, count cycles -> `init_done` rises exactly 1024 edges later. Read addresses 0, 511 and 1023 -> `rdata`=16'h0000 each.
- During the sweep, pulse `data_r`=1, `data_w`=1, addr 5, `wdata`=16'hBEEF -> `req_drop` pulses once. After `init_done`, read addr 5 -> 16'h0000.
- Write 16'h0014 to addr 0, then read addr 0 on the next cycle -> `rdata`=16'h0014 and `rdata_valid` high exactly one cycle later.
- Write 16'h5A5A to addr 1023, then write 16'h1234 to addr 0 -> `rdata` keeps its previous value; reading addr 1023 returns 16'h5A5A.
- Drive `data_w`=1 with `data_r`=0, addr 3, `wdata`=16'hFFFF -> no write; reading addr 3 returns its prior value and no `rdata_valid` pulse occurs for the ignored cycle.
- Assert `rst_n` low at sweep address 600, release -> sweep restarts at 0. `init_done` rises 1024 edges after release; `rdata` reads 16'h0000 while in reset.
